// File: rtl/ag32gbd_pkg.sv
// Shared definitions for the ag32gbd cartridge BRAM path: arbiter states,
// served-side tracking and the configuration/dither memory geometry.
package ag32gbd_pkg;

    localparam int          BRAM_DEPTH       = 1024;
    localparam logic [9:0]  BRAM_DITHER_BASE = 10'h200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WDONE = 3'd2,
        ST_READ  = 3'd3,
        ST_RCAP  = 3'd4
    } arb_state_t;

    typedef enum logic {
        SRV_READ  = 1'b0,
        SRV_WRITE = 1'b1
    } served_t;

    // Round-robin pick: a lone eligible side wins; on a tie the side not served last wins.
    function automatic logic pick_write(input logic wr_elig, input logic rd_elig,
                                        input served_t last_served);
        return wr_elig && (!rd_elig || (last_served == SRV_READ));
    endfunction

endpackage

// File: rtl/ag32gbd_bram_1p.sv
// Single-port configuration/dither BRAM with a registered read port.
// A write cycle leaves the read register unchanged.
module ag32gbd_bram_1p #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              sys_clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge sys_clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ag32gbd_bram_arb.sv
// Arbiter between register-window writes and capture-engine reads on the shared
// single-port BRAM; one transaction at a time, writes held off while the engine is locked.
module ag32gbd_bram_arb
    import ag32gbd_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              sys_clock,
    input  logic              sys_resetn,
    input  logic              Bram_Req_Write,
    input  logic [ADDR_W-1:0] Bram_Addr,
    input  logic [DATA_W-1:0] Bram_Data,
    output logic              Bram_WriteRegDone,
    input  logic              Eng_RdReq,
    input  logic [ADDR_W-1:0] Eng_RdAddr,
    input  logic              Eng_Lock,
    output logic              Eng_RdGrant,
    output logic              Eng_RdValid,
    output logic [DATA_W-1:0] Eng_RdData,
    output logic              Mem_En,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic              Arb_Busy
);

    arb_state_t        state_reg,  state_next;
    served_t           last_reg,   last_next;
    logic              en_reg,     en_next;
    logic              we_reg,     we_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic [DATA_W-1:0] wdata_reg,  wdata_next;
    logic              done_reg,   done_next;
    logic              grant_reg,  grant_next;
    logic              valid_reg,  valid_next;
    logic [DATA_W-1:0] rdata_reg,  rdata_next;

    logic wr_elig;
    logic rd_elig;

    // A locked engine only blocks acceptance; a write already past IDLE runs to completion.
    assign wr_elig = Bram_Req_Write && !Eng_Lock;
    assign rd_elig = Eng_RdReq;

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        en_next    = 1'b0;
        we_next    = 1'b0;
        addr_next  = '0;
        wdata_next = '0;
        done_next  = 1'b0;
        grant_next = 1'b0;
        valid_next = 1'b0;
        rdata_next = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (pick_write(wr_elig, rd_elig, last_reg)) begin
                    state_next = ST_WRITE;
                    last_next  = SRV_WRITE;
                    en_next    = 1'b1;
                    we_next    = 1'b1;
                    addr_next  = Bram_Addr;
                    wdata_next = Bram_Data;
                end else if (rd_elig) begin
                    state_next = ST_READ;
                    last_next  = SRV_READ;
                    en_next    = 1'b1;
                    addr_next  = Eng_RdAddr;
                    grant_next = 1'b1;
                end
            end
            ST_WRITE: begin
                state_next = ST_WDONE;
                done_next  = 1'b1;
            end
            // Guard cycle: the register block still holds its request while it sees done.
            ST_WDONE: begin
                state_next = ST_IDLE;
            end
            ST_READ: begin
                state_next = ST_RCAP;
            end
            ST_RCAP: begin
                state_next = ST_IDLE;
                rdata_next = Mem_RData;
                valid_next = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_reg <= ST_IDLE;
            last_reg  <= SRV_READ;
            en_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            done_reg  <= 1'b0;
            grant_reg <= 1'b0;
            valid_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            en_reg    <= en_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            done_reg  <= done_next;
            grant_reg <= grant_next;
            valid_reg <= valid_next;
            rdata_reg <= rdata_next;
        end
    end

    assign Mem_En            = en_reg;
    assign Mem_We            = we_reg;
    assign Mem_Addr          = addr_reg;
    assign Mem_WData         = wdata_reg;
    assign Bram_WriteRegDone = done_reg;
    assign Eng_RdGrant       = grant_reg;
    assign Eng_RdValid       = valid_reg;
    assign Eng_RdData        = rdata_reg;
    assign Arb_Busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ag32gbd_bram_arb.sv
// Scoreboard bench for the BRAM arbiter: drivers queue expectations, a negedge
// monitor checks handshakes, timing relations and read data against a memory model.
module tb_ag32gbd_bram_arb;

    logic       sys_clock;
    logic       sys_resetn;
    logic       Bram_Req_Write;
    logic [9:0] Bram_Addr;
    logic [7:0] Bram_Data;
    logic       Bram_WriteRegDone;
    logic       Eng_RdReq;
    logic [9:0] Eng_RdAddr;
    logic       Eng_Lock;
    logic       Eng_RdGrant;
    logic       Eng_RdValid;
    logic [7:0] Eng_RdData;
    logic       Mem_En;
    logic       Mem_We;
    logic [9:0] Mem_Addr;
    logic [7:0] Mem_WData;
    logic [7:0] Mem_RData;
    logic       Arb_Busy;

    ag32gbd_bram_arb dut (
        .sys_clock         (sys_clock),
        .sys_resetn        (sys_resetn),
        .Bram_Req_Write    (Bram_Req_Write),
        .Bram_Addr         (Bram_Addr),
        .Bram_Data         (Bram_Data),
        .Bram_WriteRegDone (Bram_WriteRegDone),
        .Eng_RdReq         (Eng_RdReq),
        .Eng_RdAddr        (Eng_RdAddr),
        .Eng_Lock          (Eng_Lock),
        .Eng_RdGrant       (Eng_RdGrant),
        .Eng_RdValid       (Eng_RdValid),
        .Eng_RdData        (Eng_RdData),
        .Mem_En            (Mem_En),
        .Mem_We            (Mem_We),
        .Mem_Addr          (Mem_Addr),
        .Mem_WData         (Mem_WData),
        .Mem_RData         (Mem_RData),
        .Arb_Busy          (Arb_Busy)
    );

    ag32gbd_bram_1p u_mem (
        .sys_clock (sys_clock),
        .en        (Mem_En),
        .we        (Mem_We),
        .addr      (Mem_Addr),
        .wdata     (Mem_WData),
        .rdata     (Mem_RData)
    );

    initial begin
        sys_clock = 1'b0;
        forever #5 sys_clock = ~sys_clock;
    end

    int vectors     = 0;
    int miscompares = 0;
    int we_count    = 0;
    int done_count  = 0;
    int writes_issued = 0;

    logic [17:0] wr_exp_q [$];
    logic [9:0]  rd_addr_q [$];
    logic [7:0]  rd_data_q [$];
    logic [7:0]  serve_log [$];
    logic [7:0]  model_mem [0:1023];
    bit          rand_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        int n;
        @(posedge sys_clock); #1;
        Bram_Req_Write = 1'b1;
        Bram_Addr      = a;
        Bram_Data      = d;
        wr_exp_q.push_back({a, d});
        writes_issued++;
        n = 0;
        do begin
            @(negedge sys_clock);
            n++;
        end while (!Bram_WriteRegDone && n < 500);
        chk("write_done_seen", 32'(Bram_WriteRegDone), 32'd1);
        $display("write addr=0x%03h data=0x%02h done after %0d cycles", a, d, n);
        @(posedge sys_clock); #1;
        Bram_Req_Write = 1'b0;
        Bram_Addr      = '0;
        Bram_Data      = '0;
    endtask

    task automatic do_read(input logic [9:0] a);
        int n;
        @(posedge sys_clock); #1;
        Eng_RdReq  = 1'b1;
        Eng_RdAddr = a;
        rd_addr_q.push_back(a);
        n = 0;
        do begin
            @(negedge sys_clock);
            n++;
        end while (!Eng_RdGrant && n < 500);
        chk("read_grant_seen", 32'(Eng_RdGrant), 32'd1);
        $display("read  addr=0x%03h granted after %0d cycles", a, n);
        @(posedge sys_clock); #1;
        Eng_RdReq  = 1'b0;
        Eng_RdAddr = '0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_done"},  32'(Bram_WriteRegDone), 32'd0);
        chk({tag, "_grant"}, 32'(Eng_RdGrant),       32'd0);
        chk({tag, "_valid"}, 32'(Eng_RdValid),       32'd0);
        chk({tag, "_rdata"}, 32'(Eng_RdData),        32'd0);
        chk({tag, "_en"},    32'(Mem_En),            32'd0);
        chk({tag, "_we"},    32'(Mem_We),            32'd0);
        chk({tag, "_addr"},  32'(Mem_Addr),          32'd0);
        chk({tag, "_wdata"}, 32'(Mem_WData),         32'd0);
        chk({tag, "_busy"},  32'(Arb_Busy),          32'd0);
    endtask

    // Monitor: every relation below is the externally visible timing contract.
    initial begin
        logic        we_prev, g1, g2, lock_prev;
        logic [17:0] wexp;
        logic [9:0]  raddr;
        logic [7:0]  rexp;
        we_prev = 0; g1 = 0; g2 = 0; lock_prev = 0;
        forever begin
            @(negedge sys_clock);
            if (!sys_resetn) begin
                rd_data_q.delete();
                we_prev = 0; g1 = 0; g2 = 0;
                lock_prev = Eng_Lock;
            end else begin
                chk("busy", 32'(Arb_Busy), 32'(Mem_En | Bram_WriteRegDone | g1));
                chk("done_after_we", 32'(Bram_WriteRegDone), 32'(we_prev));
                chk("valid_after_grant", 32'(Eng_RdValid), 32'(g2));
                if (!Mem_En) begin
                    chk("idle_we",    32'(Mem_We),    32'd0);
                    chk("idle_addr",  32'(Mem_Addr),  32'd0);
                    chk("idle_wdata", 32'(Mem_WData), 32'd0);
                end
                if (Mem_We) begin
                    we_count++;
                    chk("we_single_cycle", 32'(we_prev), 32'd0);
                    chk("we_not_under_lock", 32'(lock_prev), 32'd0);
                    serve_log.push_back(8'h57);
                    if (wr_exp_q.size() == 0) begin
                        chk("unexpected_write", 32'(Mem_We), 32'd0);
                    end else begin
                        wexp = wr_exp_q.pop_front();
                        chk("write_addr",  32'(Mem_Addr),  32'(wexp[17:8]));
                        chk("write_wdata", 32'(Mem_WData), 32'(wexp[7:0]));
                        model_mem[wexp[17:8]] = wexp[7:0];
                    end
                end
                if (Eng_RdGrant) begin
                    serve_log.push_back(8'h52);
                    chk("grant_en", 32'(Mem_En), 32'd1);
                    chk("grant_we", 32'(Mem_We), 32'd0);
                    if (rd_addr_q.size() == 0) begin
                        chk("unexpected_grant", 32'(Eng_RdGrant), 32'd0);
                    end else begin
                        raddr = rd_addr_q.pop_front();
                        chk("read_addr", 32'(Mem_Addr), 32'(raddr));
                        rd_data_q.push_back(model_mem[raddr]);
                    end
                end
                if (Eng_RdValid) begin
                    if (rd_data_q.size() == 0) begin
                        chk("unexpected_valid", 32'(Eng_RdValid), 32'd0);
                    end else begin
                        rexp = rd_data_q.pop_front();
                        chk("read_data", 32'(Eng_RdData), 32'(rexp));
                        $display("valid data=0x%02h expected=0x%02h", Eng_RdData, rexp);
                    end
                end
                if (Bram_WriteRegDone) done_count++;
                we_prev   = Mem_We;
                g2        = g1;
                g1        = Eng_RdGrant;
                lock_prev = Eng_Lock;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int we0, d0, n;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
        sys_resetn     = 1'b0;
        Bram_Req_Write = 1'b0;
        Bram_Addr      = '0;
        Bram_Data      = '0;
        Eng_RdReq      = 1'b0;
        Eng_RdAddr     = '0;
        Eng_Lock       = 1'b0;
        rand_done      = 1'b0;
        repeat (3) @(negedge sys_clock);
        chk_outputs_zero("reset");
        @(posedge sys_clock); #1;
        sys_resetn = 1'b1;

        // Simultaneous pair from reset: write wins the first tie.
        serve_log.delete();
        fork
            do_write(10'h205, 8'hA5);
            do_read(10'h205);
        join
        repeat (4) @(posedge sys_clock);
        chk("pair1_count", 32'(serve_log.size()), 32'd2);
        if (serve_log.size() >= 2) begin
            chk("pair1_first",  32'(serve_log[0]), 32'h57);
            chk("pair1_second", 32'(serve_log[1]), 32'h52);
        end

        // After a lone write the next tie goes to the read.
        do_write(10'h206, 8'h3C);
        serve_log.delete();
        fork
            do_write(10'h207, 8'h5A);
            do_read(10'h206);
        join
        repeat (4) @(posedge sys_clock);
        chk("pair2_count", 32'(serve_log.size()), 32'd2);
        if (serve_log.size() >= 2) begin
            chk("pair2_first",  32'(serve_log[0]), 32'h52);
            chk("pair2_second", 32'(serve_log[1]), 32'h57);
        end

        // Reset while the read is in its capture cycle.
        do_read(10'h205);
        sys_resetn = 1'b0;
        #2;
        chk_outputs_zero("midreset");
        repeat (2) @(posedge sys_clock);
        #1;
        sys_resetn = 1'b1;
        repeat (3) @(posedge sys_clock);
        do_read(10'h206);
        repeat (4) @(posedge sys_clock);

        // Request held through done: exactly one write and one done each.
        we0 = we_count;
        d0  = done_count;
        for (int i = 0; i < 16; i++) do_write(10'h200 + 10'(i), 8'($urandom_range(0, 255)));
        repeat (3) @(posedge sys_clock);
        chk("burst16_writes", 32'(we_count - we0),   32'd16);
        chk("burst16_dones",  32'(done_count - d0), 32'd16);
        for (int i = 16; i < 32; i++) do_write(10'h200 + 10'(i), 8'($urandom_range(0, 255)));

        // Pending write under lock with continuous engine reads.
        @(posedge sys_clock); #1;
        Eng_Lock = 1'b1;
        we0 = we_count;
        d0  = done_count;
        n   = 0;
        fork
            do_write(10'h208, 8'hC3);
            begin
                for (int i = 0; i < 10; i++) do_read(10'h200 + 10'($urandom_range(0, 31)));
            end
            begin
                repeat (20) @(posedge sys_clock);
                chk("no_write_under_lock", 32'(we_count - we0), 32'd0);
                #1;
                Eng_Lock = 1'b0;
                while (!Mem_We && n < 12) begin
                    @(negedge sys_clock);
                    n++;
                end
                // First negedge precedes the edge that first sees lock low.
                chk("lock_release_within_3", 32'(n >= 2 && n <= 5), 32'd1);
            end
        join
        repeat (3) @(posedge sys_clock);
        chk("lock_single_done", 32'(done_count - d0), 32'd1);

        // Randomized concurrent traffic with toggling lock.
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 40; i++) begin
                            repeat ($urandom_range(0, 4)) @(posedge sys_clock);
                            do_write(10'h200 + 10'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
                        end
                    end
                    begin
                        for (int i = 0; i < 60; i++) begin
                            repeat ($urandom_range(0, 3)) @(posedge sys_clock);
                            do_read(10'h200 + 10'($urandom_range(0, 31)));
                        end
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge sys_clock); #1;
                    if ($urandom_range(0, 7) == 0) Eng_Lock = ~Eng_Lock;
                end
                Eng_Lock = 1'b0;
            end
        join

        repeat (10) @(posedge sys_clock);
        chk("wr_queue_empty",  32'(wr_exp_q.size()),  32'd0);
        chk("rd_addr_empty",   32'(rd_addr_q.size()), 32'd0);
        chk("rd_data_empty",   32'(rd_data_q.size()), 32'd0);
        chk("total_writes",    32'(we_count),         32'(writes_issued));
        chk("total_dones",     32'(done_count),       32'(writes_issued));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ag32gbd_bram_arb.md
# ag32gbd_bram_arb

Single-port BRAM arbiter sitting directly downstream of the cartridge register block. It accepts register-window writes (Game Boy writes to RAM bank 0x10, offsets 0x06+) through a req/done handshake. It shares the same 1K×8 configuration/dither BRAM with the capture engine's read port. Under lock it guarantees engine reads are never interleaved with bus writes mid-capture.

## Interface
- ADDR_W, 10, BRAM address width
- DATA_W, 8, BRAM data width
- sys_clock  in  1  system clock, all logic rising-edge
- sys_resetn  in  1  reset sys_resetn, asynchronous, active-low; clock sys_clock
- Bram_Req_Write  in  1  write request from register block, held high until done seen
- Bram_Addr  in  ADDR_W  write address, stable while request high
- Bram_Data  in  DATA_W  write data, stable while request high
- Bram_WriteRegDone  out  1  one-cycle pulse: write committed
- Eng_RdReq  in  1  capture-engine read request (level)
- Eng_RdAddr  in  ADDR_W  read address, sampled on grant
- Eng_Lock  in  1  capture in progress; defers new bus writes
- Eng_RdGrant  out  1  one-cycle pulse: read accepted, engine may change address
- Eng_RdValid  out  1  one-cycle pulse: Eng_RdData valid
- Eng_RdData  out  DATA_W  read data, held until next valid
- Mem_En  out  1  BRAM enable
- Mem_We  out  1  BRAM write enable
- Mem_Addr  out  ADDR_W  BRAM address
- Mem_WData  out  DATA_W  BRAM write data
- Mem_RData  in  DATA_W  BRAM read data, 1-cycle registered latency
- Arb_Busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, WRITE, WDONE, READ, RCAP.
- IDLE: evaluate requests.
  - Write eligible = Bram_Req_Write && !Eng_Lock.
  - Read eligible = Eng_RdReq.
  - One eligible: serve it.
  - Both eligible: serve opposite of last_served flag (round-robin); last_served resets to READ, so the first conflict goes to WRITE.
- Write path:
  - IDLE→WRITE registers Mem_En=1, Mem_We=1, Mem_Addr=Bram_Addr, Mem_WData=Bram_Data.
  - WRITE→WDONE drops Mem_En/Mem_We and pulses Bram_WriteRegDone.
  - WDONE→IDLE unconditionally. The guard cycle prevents re-accepting the still-high request.
- Read path:
  - IDLE→READ registers Mem_En=1, Mem_We=0, Mem_Addr=Eng_RdAddr and pulses Eng_RdGrant.
  - READ→RCAP drops Mem_En.
  - RCAP→IDLE captures Mem_RData into Eng_RdData and pulses Eng_RdValid.
- One transaction in flight at a time; no pipelining.
- Eng_Lock only gates acceptance. A write already in WRITE/WDONE completes if lock rises. A deferred write stays pending, with no loss, until lock falls.
- Addresses are passed verbatim, with no range check. Wrap-around is the caller's concern.
- Mem_Addr/Mem_WData return to 0 when Mem_En drops.

## Timing
- Reset values of every output are 0: Bram_WriteRegDone, Eng_RdGrant, Eng_RdValid, Eng_RdData, Mem_En, Mem_We, Mem_Addr, Mem_WData, Arb_Busy. State is IDLE, last_served is READ.
- Reset mid-transaction: the in-flight read is discarded with no Eng_RdValid. An in-flight write may or may not have reached BRAM; done is never pulsed.
- Write latency: request sampled at edge k → Mem_We high k..k+1 → done high k+1..k+2 → idle at k+2. Earliest next acceptance is edge k+3.
- Read latency: request sampled at edge k → grant pulse k..k+1 → Eng_RdValid k+2..k+3. Back-to-back reads run every 3 cycles.
- Simultaneous request after a write: the next served request is the read, and vice versa.
- Arb_Busy is high exactly while state ≠ IDLE.

## Structure
- Shared package ag32gbd_pkg:
  - state enum
  - BRAM_DITHER_BASE = 10'h200
  - BRAM_DEPTH = 1024
- No sub-module inside the arbiter.
- BRAM is a separate instance, ag32gbd_bram_1p, provided at integration level and used by the bench as the memory model.

## Test plan
- Write Addr=0x205, Data=0xA5, no lock → Mem_We one cycle at 0x205, done pulse one cycle later, BRAM[0x205]=0xA5, Arb_Busy low after 3 cycles.
- Engine read of 0x205 after that write → grant pulse, Eng_RdValid 2 cycles later with Eng_RdData=0xA5.
- Eng_Lock=1 with write request pending for 20 cycles plus continuous engine reads → no Mem_We during lock; write commits within 3 cycles of lock falling; done pulses exactly once.
- Write and read requests both rise in the same cycle from reset → write served first, then read; next simultaneous pair served read first.
- Reset asserted during RCAP → no Eng_RdValid; all outputs 0; state IDLE; a new read after reset returns correct data.
- Reg block holds request high through done → exactly one BRAM write and one done pulse per request, checked over 16 writes to 0x200–0x20F.
